// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator.
//   DATA_WIDTH_DEF : default pixel width (raw FP32 pattern)
//   STAGE_EN_W     : width of the convolution stage-enable vector
//   cnt_w()        : bit width of a 0..n-1 position counter
package window_gen_3x3_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned STAGE_EN_W     = 4;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out bundle of the 3x3 window generator.
//   in_valid, in_data : raster-order pixel stream (no backpressure)
//   i1..i9            : window operands, row-major, i1 top-left
//   valid_out         : one-cycle strobe, new window on i1..i9
//   valid_pipe        : capture enables for convolution stages 2..5
//   frame_done        : one-cycle strobe after the last pixel of a frame
// Modports: master = pixel source / window sink, slave = generator.
interface window_gen_3x3_if
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [DATA_WIDTH-1:0] i1, i2, i3, i4, i5, i6, i7, i8, i9;
  logic                  valid_out;
  logic [STAGE_EN_W-1:0] valid_pipe;
  logic                  frame_done;

  modport master (
    output in_valid, in_data,
    input  i1, i2, i3, i4, i5, i6, i7, i8, i9, valid_out, valid_pipe, frame_done
  );

  modport slave (
    input  in_valid, in_data,
    output i1, i2, i3, i4, i5, i6, i7, i8, i9, valid_out, valid_pipe, frame_done
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// One image-row buffer: DEPTH x DATA_WIDTH, asynchronous read, clocked write.
// A read and write to the same index in one cycle returns the old contents.
// Contents are never reset.
//   clk   : rising-edge clock
//   we    : write enable
//   addr  : shared read/write index
//   wdata : data written at addr
//   rdata : data currently stored at addr
module line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 224,
  parameter int unsigned AW         = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator feeding the FP32 conv pipeline.
// Buffers two rows; after accepting p(r,c) with r>=2, c>=2 it presents
// p(r-2..r, c-2..c) on i1..i9 with a one-cycle valid_out strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous frame restart (wins over in_valid)
//   bus        : window_gen_3x3_if slave (pixel in, window/strobes out)
// Build option: WINGEN_PIPE_VALID_EN -- when defined, valid_pipe is a
// 4-stage delay of valid_out; otherwise it is tied to all ones.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IMG_W      = 224,
  parameter int unsigned IMG_H      = 224
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  window_gen_3x3_if.slave  bus
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic                  accept;
  logic [CW-1:0]         col_q;
  logic [RW-1:0]         row_q;
  logic                  col_last, row_last;
  logic [DATA_WIDTH-1:0] lb_a_rd, lb_b_rd;
  logic                  valid_q, done_q;

  // Column taps: [0] = column c (newest), [2] = column c-2 (oldest)
  logic [2:0][DATA_WIDTH-1:0] top_q, mid_q, bot_q;

  assign accept   = bus.in_valid & ~clr;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clr) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // lb_a holds row r-1, lb_b row r-2; both shift down one row per access.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (bus.in_data),
    .rdata (lb_a_rd)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W), .AW(CW)) u_lb_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb_a_rd),
    .rdata (lb_b_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept) begin
      top_q <= {top_q[1:0], lb_b_rd};
      mid_q <= {mid_q[1:0], lb_a_rd};
      bot_q <= {bot_q[1:0], bus.in_data};
    end
  end

  // Stale line-buffer data is never exposed: windows start only at r>=2, c>=2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_q  <= accept && col_last && row_last;
    end
  end

`ifdef WINGEN_PIPE_VALID_EN
  logic [STAGE_EN_W-1:0] pipe_q;

  // Keeps shifting through clr so in-flight windows drain downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= {pipe_q[STAGE_EN_W-2:0], valid_q};
  end

  assign bus.valid_pipe = pipe_q;
`else
  assign bus.valid_pipe = '1;
`endif

  assign bus.valid_out  = valid_q;
  assign bus.frame_done = done_q;

  assign bus.i1 = top_q[2];
  assign bus.i2 = top_q[1];
  assign bus.i3 = top_q[0];
  assign bus.i4 = mid_q[2];
  assign bus.i5 = mid_q[1];
  assign bus.i6 = mid_q[0];
  assign bus.i7 = bot_q[2];
  assign bus.i8 = bot_q[1];
  assign bus.i9 = bot_q[0];

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  window_gen_3x3_if #(.DATA_WIDTH(32)) bus ();

  window_gen_3x3 #(.DATA_WIDTH(32), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int win_cnt = 0;

  // Reference model: the current frame as a 2D image plus raster position.
  logic [31:0] img [H][W];
  int          pr, pc;
  logic        last_ev;
  logic [3:0]  pipe_exp;
  logic        ev_now, ed_now;
  logic [31:0] ew [9];

  typedef struct packed {
    logic             v;
    logic             c;
    logic [31:0]      d;
    logic             ev;
    logic             ed;
    logic [8:0][31:0] w;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_win(input int k);
    case (k)
      0: return bus.i1;
      1: return bus.i2;
      2: return bus.i3;
      3: return bus.i4;
      4: return bus.i5;
      5: return bus.i6;
      6: return bus.i7;
      7: return bus.i8;
      default: return bus.i9;
    endcase
  endfunction

  function automatic logic [3:0] pipe_expected();
`ifdef WINGEN_PIPE_VALID_EN
    return pipe_exp;
`else
    return 4'hf;
`endif
  endfunction

  task automatic model_step(input bit v, input logic [31:0] d, input bit c);
    pipe_exp = {pipe_exp[2:0], last_ev};
    ev_now = 1'b0;
    ed_now = 1'b0;
    if (c) begin
      pr = 0;
      pc = 0;
    end else if (v) begin
      img[pr][pc] = d;
      if (pr >= 2 && pc >= 2) begin
        ev_now = 1'b1;
        for (int k = 0; k < 9; k++) ew[k] = img[pr - 2 + k / 3][pc - 2 + k % 3];
      end
      if (pr == H - 1 && pc == W - 1) ed_now = 1'b1;
      pc++;
      if (pc == W) begin
        pc = 0;
        pr = (pr + 1) % H;
      end
    end
    last_ev = ev_now;
  endtask

  task automatic step(input bit v, input logic [31:0] d, input bit c);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    clr          = c;
    @(posedge clk);
    #1;
    model_step(v, d, c);
    if (bus.valid_out === 1'b1) win_cnt++;
    chk("valid_out", {31'b0, bus.valid_out}, {31'b0, ev_now});
    chk("frame_done", {31'b0, bus.frame_done}, {31'b0, ed_now});
    chk("valid_pipe", {28'b0, bus.valid_pipe}, {28'b0, pipe_expected()});
    if (ev_now)
      for (int k = 0; k < 9; k++) chk($sformatf("win_i%0d", k + 1), act_win(k), ew[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 9; k++) chk($sformatf("%s_i%0d", tag, k + 1), act_win(k), 32'h0);
    chk({tag, "_valid_out"}, {31'b0, bus.valid_out}, 32'h0);
    chk({tag, "_frame_done"}, {31'b0, bus.frame_done}, 32'h0);
`ifdef WINGEN_PIPE_VALID_EN
    chk({tag, "_valid_pipe"}, {28'b0, bus.valid_pipe}, 32'h0);
`else
    chk({tag, "_valid_pipe"}, {28'b0, bus.valid_pipe}, 32'hf);
`endif
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    clr          = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    check_reset_outputs("rst_hold");
    @(negedge clk);
    rst_n    = 1'b1;
    pr       = 0;
    pc       = 0;
    pipe_exp = '0;
    last_ev  = 1'b0;
  endtask

  task automatic frame(input int base);
    for (int i = 0; i < W * H; i++) step(1'b1, 32'(base + i), 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    pr = 0; pc = 0; pipe_exp = '0; last_ev = 1'b0;
    #2;
    check_reset_outputs("rst_init");
    do_reset(3);

    // Continuous frame, expected values from the raster indexing 0..15
    for (int i = 0; i < 16; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      tbl[i].v  = 1'b1;
      tbl[i].c  = 1'b0;
      tbl[i].d  = 32'(i);
      tbl[i].ev = (r >= 2 && c >= 2);
      tbl[i].ed = (i == 15);
      for (int k = 0; k < 9; k++)
        tbl[i].w[k] = tbl[i].ev ? 32'(i - (2 - k / 3) * W - (2 - k % 3)) : 32'h0;
    end
    win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk("tbl_valid", {31'b0, bus.valid_out}, {31'b0, tbl[i].ev});
      chk("tbl_done", {31'b0, bus.frame_done}, {31'b0, tbl[i].ed});
      if (tbl[i].ev)
        for (int k = 0; k < 9; k++) chk($sformatf("tbl_p%0d_i%0d", i, k + 1), act_win(k), tbl[i].w[k]);
    end
    chk("tbl_win_count", 32'(win_cnt), 32'd4);

    // Idle cycle after every pixel
    win_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'(i), 1'b0);
      step(1'b0, 32'hdead_beef, 1'b0);
    end
    chk("idle_win_count", 32'(win_cnt), 32'd4);

    // Back-to-back frames, second offset by 100
    frame(0);
    step(1'b1, 32'd100, 1'b0);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 32'(100 + i), 1'b0);
      if (i == 10) begin
        chk("b2b_first_i1", bus.i1, 32'd100);
        chk("b2b_first_i5", bus.i5, 32'd105);
        chk("b2b_first_i9", bus.i9, 32'd110);
      end
    end

    // Isolated window followed by idles: valid_pipe walks through all stages
    for (int i = 0; i <= 10; i++) step(1'b1, 32'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0);
    for (int i = 11; i < 16; i++) step(1'b1, 32'(i), 1'b0);

    // Reset mid-frame after pixel 9, then a clean frame
    for (int i = 0; i <= 9; i++) step(1'b1, 32'(i), 1'b0);
    do_reset(2);
    win_cnt = 0;
    frame(0);
    chk("rst_win_count", 32'(win_cnt), 32'd4);

    // clr collides with pixel 6, which must be dropped
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b1, 32'd6, 1'b1);
    win_cnt = 0;
    frame(0);
    chk("clr_win_count", 32'(win_cnt), 32'd4);

    // Randomized traffic: random data, idles and occasional clr
    for (int i = 0; i < 400; i++) begin
      bit v, c;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 63) == 0);
      step(v, $urandom, c);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
